// File: rtl/ibuffer_wr_arbiter_pkg.sv
// Purpose: shared types and defaults for the ibuffer write arbiter and the iDMA write path.
// Contents: default widths, FSM state encoding, requester port indices, grant-state helper.
// Used by: ibuffer_wr_arbiter, ibuffer_burst_cnt.
package ibuffer_wr_arbiter_pkg;

  // Default widths, shared with the iDMA write path.
  localparam int unsigned IBUF_DATA_WIDTH = 128;
  localparam int unsigned IBUF_MEM_AW     = 15;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_e;

  localparam logic PORT0 = 1'b0;  // iDMA write path
  localparam logic PORT1 = 1'b1;  // NoC / host write path

  // Grant state that corresponds to a requester index.
  function automatic arb_state_e gnt_state(input logic port);
    return (port == PORT1) ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/ibuffer_burst_cnt.sv
// Purpose: latches the granted burst length and counts accepted beats, flagging the last one.
// Latency: last_beat is combinational with the beat handshake; load takes effect next cycle.
// Backpressure: counts only beats the caller reports as handshaken; holds otherwise.
// Ports: clk/rst_n; load + load_len (grant); beat (handshake); last_beat (final beat of burst).
module ibuffer_burst_cnt
  import ibuffer_wr_arbiter_pkg::*;
#(
  parameter int unsigned MEM_AW = IBUF_MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [MEM_AW-1:0] load_len,
  input  logic              beat,
  output logic              last_beat
);

  logic [MEM_AW-1:0] len_q, len_d;
  logic [MEM_AW-1:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    if (load) begin
      // A zero length still moves one beat, so it is promoted to 1.
      len_d      = (load_len == '0) ? MEM_AW'(1) : load_len;
      beat_cnt_d = '0;
    end else if (beat) begin
      beat_cnt_d = beat_cnt_q + MEM_AW'(1);
    end
  end

  // len_q is never 0 once loaded, so len_q-1 cannot underflow during a grant.
  assign last_beat = beat && (beat_cnt_q == (len_q - MEM_AW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      beat_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: rtl/ibuffer_wr_arbiter.sv
// Purpose: shares the single ibuffer write port between iDMA (port 0) and NoC/host (port 1), whole bursts, round-robin.
// Latency: 1 arbitration cycle per burst, then 0-cycle combinational beat path; 1 idle cycle between grants.
// Backpressure: ibuffer_ready is forwarded to the granted port only; the grant holds through any stall.
// Ports: req{0,1}_* requester side (cen/wen/addr/wdata/strb/len in, ready/done out);
//        ibuffer_* memory side (cen/wen/addr/wdata/strb out, ready in); arb_busy/arb_owner status.
module ibuffer_wr_arbiter
  import ibuffer_wr_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = IBUF_DATA_WIDTH,
  parameter int unsigned MEM_AW     = IBUF_MEM_AW,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [MEM_AW-1:0]     req0_len,
  input  logic                  req0_cen,
  input  logic                  req0_wen,
  input  logic [MEM_AW-1:0]     req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic [STRB_WIDTH-1:0] req0_strb,
  output logic                  req0_ready,
  output logic                  req0_done,

  input  logic [MEM_AW-1:0]     req1_len,
  input  logic                  req1_cen,
  input  logic                  req1_wen,
  input  logic [MEM_AW-1:0]     req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic [STRB_WIDTH-1:0] req1_strb,
  output logic                  req1_ready,
  output logic                  req1_done,

  output logic                  ibuffer_cen,
  output logic                  ibuffer_wen,
  input  logic                  ibuffer_ready,
  output logic [MEM_AW-1:0]     ibuffer_addr,
  output logic [DATA_WIDTH-1:0] ibuffer_wdata,
  output logic [STRB_WIDTH-1:0] ibuffer_strb,

  output logic                  arb_busy,
  output logic                  arb_owner
);

  arb_state_e        state_q, state_d;
  logic              last_owner_q, last_owner_d;

  logic              grant_vld;
  logic              grant_port;
  logic [MEM_AW-1:0] grant_len;
  logic              load;
  logic              beat_hs;
  logic              last_beat;

  // Arbitration: a lone requester wins; on a tie the port that did not go last wins.
  assign grant_vld  = req0_cen | req1_cen;
  assign grant_port = (req0_cen & req1_cen) ? ~last_owner_q : req1_cen;
  assign grant_len  = (grant_port == PORT1) ? req1_len : req0_len;
  assign load       = (state_q == ARB_IDLE) && grant_vld;

  // Beat mux. Everything is quiet in IDLE so the SRAM pins do not toggle between bursts.
  always_comb begin
    ibuffer_cen   = 1'b0;
    ibuffer_wen   = 1'b0;
    ibuffer_addr  = '0;
    ibuffer_wdata = '0;
    ibuffer_strb  = '0;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    arb_owner     = last_owner_q;
    case (state_q)
      ARB_GNT0: begin
        ibuffer_cen   = req0_cen;
        ibuffer_wen   = req0_wen;
        ibuffer_addr  = req0_addr;
        ibuffer_wdata = req0_wdata;
        ibuffer_strb  = req0_strb;
        req0_ready    = ibuffer_ready;
        arb_owner     = PORT0;
      end
      ARB_GNT1: begin
        ibuffer_cen   = req1_cen;
        ibuffer_wen   = req1_wen;
        ibuffer_addr  = req1_addr;
        ibuffer_wdata = req1_wdata;
        ibuffer_strb  = req1_strb;
        req1_ready    = ibuffer_ready;
        arb_owner     = PORT1;
      end
      default: ;
    endcase
  end

  assign beat_hs  = ibuffer_cen & ibuffer_ready;
  assign arb_busy = (state_q != ARB_IDLE);

  ibuffer_burst_cnt #(
    .MEM_AW (MEM_AW)
  ) u_burst_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_len  (grant_len),
    .beat      (beat_hs),
    .last_beat (last_beat)
  );

  // Next state and done pulses. A grant always drops back to IDLE after its last
  // beat, which is what guarantees the idle cycle between consecutive bursts.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    req0_done    = 1'b0;
    req1_done    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (grant_vld) state_d = gnt_state(grant_port);
      end
      ARB_GNT0: begin
        if (last_beat) begin
          req0_done    = 1'b1;
          last_owner_d = PORT0;
          state_d      = ARB_IDLE;
        end
      end
      ARB_GNT1: begin
        if (last_beat) begin
          req1_done    = 1'b1;
          last_owner_d = PORT1;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // last_owner resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= PORT1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

endmodule

// File: tb/tb_ibuffer_wr_arbiter.sv
module tb_ibuffer_wr_arbiter;

  localparam int DW = 128;
  localparam int AW = 15;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] req0_len, req1_len, req0_addr, req1_addr;
  logic          req0_cen, req1_cen, req0_wen, req1_wen;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic [SW-1:0] req0_strb, req1_strb;
  logic          req0_ready, req1_ready, req0_done, req1_done;
  logic          ibuffer_cen, ibuffer_wen, ibuffer_ready;
  logic [AW-1:0] ibuffer_addr;
  logic [DW-1:0] ibuffer_wdata;
  logic [SW-1:0] ibuffer_strb;
  logic          arb_busy, arb_owner;

  always #5 clk = ~clk;

  ibuffer_wr_arbiter #(.DATA_WIDTH(DW), .MEM_AW(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_len(req0_len), .req0_cen(req0_cen), .req0_wen(req0_wen), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_len(req1_len), .req1_cen(req1_cen), .req1_wen(req1_wen), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_ready(req1_ready), .req1_done(req1_done),
    .ibuffer_cen(ibuffer_cen), .ibuffer_wen(ibuffer_wen), .ibuffer_ready(ibuffer_ready),
    .ibuffer_addr(ibuffer_addr), .ibuffer_wdata(ibuffer_wdata), .ibuffer_strb(ibuffer_strb),
    .arb_busy(arb_busy), .arb_owner(arb_owner)
  );

  typedef struct packed {
    logic          cen;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic          rdy0;
    logic          rdy1;
    logic          done0;
    logic          done1;
    logic          busy;
    logic          owner;
  } obs_t;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the port and how many beats are still owed.
  bit m_busy;
  bit m_owner;
  bit m_last;
  int m_left;

  // Bench-side requesters.
  bit p_pend[2];
  int p_len[2];
  int p_base[2];
  int p_sent[2];

  function automatic obs_t model_eval();
    obs_t e = '0;
    e.busy  = m_busy;
    e.owner = m_busy ? m_owner : m_last;
    if (m_busy && !m_owner) begin
      e.cen = req0_cen; e.wen = req0_wen; e.addr = req0_addr; e.wdata = req0_wdata; e.strb = req0_strb;
      e.rdy0  = ibuffer_ready;
      e.done0 = req0_cen && ibuffer_ready && (m_left == 1);
    end else if (m_busy) begin
      e.cen = req1_cen; e.wen = req1_wen; e.addr = req1_addr; e.wdata = req1_wdata; e.strb = req1_strb;
      e.rdy1  = ibuffer_ready;
      e.done1 = req1_cen && ibuffer_ready && (m_left == 1);
    end
    return e;
  endfunction

  function automatic obs_t dut_obs();
    obs_t a;
    a.cen = ibuffer_cen; a.wen = ibuffer_wen; a.addr = ibuffer_addr; a.wdata = ibuffer_wdata;
    a.strb = ibuffer_strb; a.rdy0 = req0_ready; a.rdy1 = req1_ready; a.done0 = req0_done;
    a.done1 = req1_done; a.busy = arb_busy; a.owner = arb_owner;
    return a;
  endfunction

  task automatic drive_inputs();
    req0_cen   = p_pend[0];
    req1_cen   = p_pend[1];
    // Length only matters at grant time; scramble it otherwise to show it is frozen.
    req0_len   = m_busy ? AW'($urandom) : AW'(p_len[0]);
    req1_len   = m_busy ? AW'($urandom) : AW'(p_len[1]);
    req0_addr  = AW'(p_base[0] + p_sent[0]);
    req1_addr  = AW'(p_base[1] + p_sent[1]);
    req0_wdata = {$urandom, $urandom, $urandom, $urandom};
    req1_wdata = {$urandom, $urandom, $urandom, $urandom};
    req0_strb  = SW'($urandom);
    req1_strb  = SW'($urandom);
    req0_wen   = 1'($urandom);
    req1_wen   = 1'($urandom);
  endtask

  task automatic model_tick();
    int ln;
    bit c;
    if (!m_busy) begin
      if (req0_cen || req1_cen) begin
        m_owner = (req0_cen && req1_cen) ? !m_last : !req0_cen;
        ln      = m_owner ? int'(req1_len) : int'(req0_len);
        m_left  = (ln == 0) ? 1 : ln;
        m_busy  = 1'b1;
      end
    end else begin
      c = m_owner ? req1_cen : req0_cen;
      if (c && ibuffer_ready) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
  endtask

  // The only way a test crosses a rising edge: model and requesters advance with it.
  task automatic tick();
    obs_t e;
    @(posedge clk);
    e = model_eval();
    if (e.rdy0 && req0_cen) p_sent[0]++;
    if (e.rdy1 && req1_cen) p_sent[1]++;
    if (e.done0) p_pend[0] = 1'b0;
    if (e.done1) p_pend[1] = 1'b0;
    model_tick();
    #1 drive_inputs();
  endtask

  task automatic clear_all();
    m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_left = 0;
    p_pend = '{1'b0, 1'b0}; p_len = '{0, 0}; p_base = '{0, 0}; p_sent = '{0, 0};
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    clear_all();
    ibuffer_ready = 1'b1;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    obs_t a, e;
    #1 rst_n = 1'b0;
    clear_all();
    ibuffer_ready = 1'b1;
    drive_inputs();
    #2;
    e = '0; e.owner = 1'b1;
    a = dut_obs();
    checks++;
    if (a !== e) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", a, e); end
    p_pend = '{1'b1, 1'b1};
    drive_inputs();
    #1 a = dut_obs();
    checks++;
    if (a !== e) begin errors++; $display("FAIL reset_hold_with_req got=%h exp=%h", a, e); end
    p_pend = '{1'b0, 1'b0};
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1 a = dut_obs();
    checks++;
    if (a !== e) begin errors++; $display("FAIL reset_release got=%h exp=%h", a, e); end
    tick();
  endtask

  task automatic test_single_port();
    obs_t a, e;
    p_len[0] = 4; p_base[0] = 0; p_sent[0] = 0; p_pend[0] = 1'b1;
    ibuffer_ready = 1'b1;
    drive_inputs();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL single_model k=%0d got=%h exp=%h", k, a, e); end
      checks++;
      if (k == 0) begin
        if (a.cen !== 1'b0 || a.busy !== 1'b0)
          begin errors++; $display("FAIL single_arb_cycle cen=%b busy=%b exp 0 0", a.cen, a.busy); end
      end else if (k < 5) begin
        if (a.cen !== 1'b1 || a.addr !== AW'(k - 1) || a.done0 !== (k == 4))
          begin errors++; $display("FAIL single_beat k=%0d cen=%b addr=%0d done=%b", k, a.cen, a.addr, a.done0); end
      end else begin
        if (a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop busy=%b exp 0", a.busy); end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    obs_t a, e;
    bit prev_busy = 1'b0;
    bit rearmed = 1'b0;
    bit done_all = 1'b0;
    bit got[$];
    bit exp_seq[4];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1};
    apply_reset();
    p_len = '{2, 2}; p_base = '{16, 32}; p_sent = '{0, 0}; p_pend = '{1'b1, 1'b1};
    ibuffer_ready = 1'b1;
    drive_inputs();
    for (int k = 0; k < 40 && !done_all; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rr_model k=%0d got=%h exp=%h", k, a, e); end
      if (a.busy && !prev_busy) got.push_back(a.owner);
      prev_busy = a.busy;
      tick();
      if (!rearmed && !p_pend[0] && !p_pend[1]) begin
        rearmed = 1'b1;
        p_sent = '{0, 0}; p_pend = '{1'b1, 1'b1};
        drive_inputs();
      end else if (rearmed && !p_pend[0] && !p_pend[1] && !m_busy) begin
        done_all = 1'b1;
      end
    end
    checks++;
    if (got.size() != 4 || !done_all)
      begin errors++; $display("FAIL rr_grant_count got=%0d exp=4 finished=%b", got.size(), done_all); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== exp_seq[i]) begin errors++; $display("FAIL rr_order grant%0d owner=%b exp=%b", i, got[i], exp_seq[i]); end
    end
  endtask

  task automatic test_ready_toggle();
    obs_t a, e;
    int hs = 0;
    bit seen_done = 1'b0;
    p_len[1] = 3; p_base[1] = 100; p_sent[1] = 0; p_pend[1] = 1'b1;
    drive_inputs();
    for (int k = 0; k < 30; k++) begin
      ibuffer_ready = 1'(k % 2);
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL toggle_model k=%0d got=%h exp=%h", k, a, e); end
      checks++;
      if (a.rdy0 !== 1'b0) begin errors++; $display("FAIL toggle_rdy0 k=%0d got=%b exp=0", k, a.rdy0); end
      if (a.cen && ibuffer_ready) hs++;
      if (a.done1) begin
        seen_done = 1'b1;
        checks++;
        if (hs != 3) begin errors++; $display("FAIL toggle_done_beat hs=%0d exp=3", hs); end
      end
      tick();
      if (seen_done && !m_busy) break;
    end
    checks++;
    if (!seen_done || hs != 3) begin errors++; $display("FAIL toggle_handshakes hs=%0d exp=3 done=%b", hs, seen_done); end
    ibuffer_ready = 1'b1;
  endtask

  task automatic test_len0();
    obs_t a, e;
    int hs = 0;
    bit seen_done = 1'b0;
    p_len[0] = 0; p_base[0] = 50; p_sent[0] = 0; p_pend[0] = 1'b1;
    ibuffer_ready = 1'b1;
    drive_inputs();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL len0_model k=%0d got=%h exp=%h", k, a, e); end
      if (a.cen && ibuffer_ready) hs++;
      if (a.done0) begin
        seen_done = 1'b1;
        checks++;
        if (hs != 1 || k != 1) begin errors++; $display("FAIL len0_done hs=%0d k=%0d exp hs=1 k=1", hs, k); end
      end
      tick();
      if (seen_done && !m_busy) break;
    end
    checks++;
    if (!seen_done || hs != 1) begin errors++; $display("FAIL len0_beats hs=%0d exp=1 done=%b", hs, seen_done); end
  endtask

  task automatic test_no_starve();
    obs_t a, e;
    int k_done = -1;
    int k_gnt1 = -1;
    bit armed = 1'b0;
    bit fin = 1'b0;
    p_len = '{8, 2}; p_base = '{300, 400}; p_sent = '{0, 0}; p_pend = '{1'b1, 1'b0};
    ibuffer_ready = 1'b1;
    drive_inputs();
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL starve_model k=%0d got=%h exp=%h", k, a, e); end
      if (a.busy && !a.owner) begin
        checks++;
        if (a.rdy1 !== 1'b0) begin errors++; $display("FAIL starve_preempt k=%0d rdy1=%b exp=0", k, a.rdy1); end
      end
      if (a.done0) k_done = k;
      if (k_gnt1 < 0 && a.busy && a.owner) k_gnt1 = k;
      tick();
      if (!armed && p_sent[0] == 2) begin
        armed = 1'b1; p_pend[1] = 1'b1;
        drive_inputs();
      end
      if (armed && !p_pend[0] && !p_pend[1] && !m_busy) fin = 1'b1;
    end
    checks++;
    if (!fin || k_done < 0 || k_gnt1 != k_done + 2)
      begin errors++; $display("FAIL starve_wait done_k=%0d gnt1_k=%0d exp gnt1=done+2 fin=%b", k_done, k_gnt1, fin); end
  endtask

  task automatic test_reset_mid();
    obs_t a, e, z;
    bit hit = 1'b0;
    bit seen_done = 1'b0;
    bit first = 1'b1;
    int hs = 0;
    z = '0; z.owner = 1'b1;
    p_len[0] = 6; p_base[0] = 200; p_sent[0] = 0; p_pend[0] = 1'b1;
    ibuffer_ready = 1'b1;
    drive_inputs();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, a, e); end
      if (p_sent[0] == 3) begin hit = 1'b1; break; end
      tick();
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rstmid_reach sent=%0d exp=3", p_sent[0]); end
    #1 rst_n = 1'b0;
    #1 a = dut_obs();
    checks++;
    if (a !== z) begin errors++; $display("FAIL rstmid_outputs got=%h exp=%h", a, z); end
    m_busy = 1'b0; m_last = 1'b1; m_left = 0;
    p_len[0] = 2; p_sent[0] = 0;
    drive_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      a = dut_obs(); e = model_eval();
      checks++;
      if (a !== e) begin errors++; $display("FAIL rstmid_restart k=%0d got=%h exp=%h", k, a, e); end
      if (a.cen && ibuffer_ready) begin
        hs++;
        if (first) begin
          first = 1'b0;
          checks++;
          if (a.addr !== AW'(200)) begin errors++; $display("FAIL rstmid_first_addr got=%0d exp=200", a.addr); end
        end
      end
      if (a.done0) begin
        seen_done = 1'b1;
        checks++;
        if (hs != 2) begin errors++; $display("FAIL rstmid_done_beat hs=%0d exp=2", hs); end
      end
      tick();
      if (seen_done && !m_busy) break;
    end
    checks++;
    if (!seen_done) begin errors++; $display("FAIL rstmid_no_done hs=%0d exp done after 2", hs); end
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_ready_toggle();
    test_len0();
    test_no_starve();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibuffer_wr_arbiter.md
Name: ibuffer_wr_arbiter

Overview:
- Shares one ibuffer write port between two independent write requesters: port 0 (iDMA write path) and port 1 (NoC/host write path).
- Grants whole bursts with round-robin fairness, and locks the grant until the burst's last beat completes.
- Sits between the pipelined iDMA write stage and the ibuffer SRAM wrapper; uses the same cen/wen/ready handshake on both sides.

Parameters:
- DATA_WIDTH, 128, write data width in bits.
- MEM_AW, 15, ibuffer address width; also the width of burst length and beat counter.
- STRB_WIDTH, DATA_WIDTH/8, byte strobe width.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- req0_len  input  MEM_AW  beats in port-0 burst; 0 is treated as 1
- req0_cen  input  1  port-0 beat valid / burst request
- req0_wen  input  1  port-0 write enable
- req0_addr  input  MEM_AW  port-0 beat address
- req0_wdata  input  DATA_WIDTH  port-0 beat data
- req0_strb  input  STRB_WIDTH  port-0 byte strobes
- req0_ready  output  1  port-0 beat accepted
- req0_done  output  1  pulse on port-0 last beat handshake
- req1_*  same set as port 0, for port 1
- ibuffer_cen  output  1  beat valid to ibuffer
- ibuffer_wen  output  1  write enable to ibuffer
- ibuffer_ready  input  1  ibuffer accepts beat
- ibuffer_addr  output  MEM_AW  muxed address
- ibuffer_wdata  output  DATA_WIDTH  muxed data
- ibuffer_strb  output  STRB_WIDTH  muxed strobes
- arb_busy  output  1  high while a grant is held
- arb_owner  output  1  current or last granted port

Behaviour:
- FSM states: IDLE, GNT0, GNT1.
- Reset values: state IDLE, last_owner 1 (so port 0 wins the first tie), beat_cnt 0, len_q 0.
- Reset values of outputs: arb_busy 0, arb_owner 1, ibuffer_cen 0; all other outputs 0.
- IDLE arbitration:
  - Sample req0_cen/req1_cen.
  - One requester: grant it.
  - Both: grant the port != last_owner.
  - On grant, register len_q = (reqN_len==0 ? 1 : reqN_len), clear beat_cnt, move to GNTn next cycle.
  - Arbitration costs 1 cycle; no ready is asserted in IDLE.
- GNTn datapath (combinational, 0 added latency):
  - ibuffer_{cen,wen,addr,wdata,strb} = reqN_*.
  - reqN_ready = ibuffer_ready.
  - The other port sees ready 0.
- Handshake = ibuffer_cen && ibuffer_ready; beat_cnt increments on each handshake.
- Last beat: handshake with beat_cnt == len_q-1.
  - reqN_done pulses in that same cycle.
  - last_owner <= n; state -> IDLE.
- Bursts are not back-to-back: there is always at least 1 IDLE cycle between grants.
- Outside the granted port: ibuffer_* data outputs are driven 0 in IDLE (no toggling); req*_done is 0.
- The grant is never preempted. A pending request on the other port waits; no starvation beyond one burst.
- Requester cen deasserted mid-burst: the grant is held, ibuffer_cen follows it low, and the count pauses.
- len value change during a burst: ignored (len_q is frozen).
- ibuffer_ready held low: the grant is held indefinitely.
- Counter arithmetic is MEM_AW wide and unsigned. len_q max is 2^MEM_AW-1, so there is no wrap inside a burst.
- arb_busy = (state != IDLE). arb_owner = granted port in GNTn, last_owner in IDLE.
- Reset mid-burst: returns immediately to IDLE with counters cleared. The aborted burst is not resumed; the requester must restart it.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the port index constants.
- Shared package: the default width parameters DATA_WIDTH/MEM_AW, shared with the iDMA write path.
- One natural sub-module: ibuffer_burst_cnt (len latch, beat counter, last-beat detect), instantiated once.

Test Plan:
- Port 0 only, req0_len=4, ibuffer_ready=1:
  - 1 IDLE cycle, then 4 consecutive beats at addr 0..3.
  - req0_done pulses on beat 4; arb_busy falls the next cycle.
- Both ports request in the same cycle, len 2 each, after reset:
  - Port 0 granted first; port 1 granted after 1 IDLE cycle.
  - Then both request again: port 0 wins (round-robin).
- Port 1 len=3 with ibuffer_ready toggling 1,0,1,0,1:
  - Exactly 3 handshakes; req1_done coincides with the third.
  - req0_ready stays 0 throughout.
- req0_len=0: treated as a 1-beat burst; req0_done pulses on the first handshake.
- Port 0 burst len=8, req1_cen rises at beat 2: port 1 waits until port 0's done, then gets the grant after 1 IDLE cycle.
- rst_n asserted at beat 3 of a len=6 burst:
  - All outputs go to 0 immediately; arb_owner goes to 1.
  - After release, a new request restarts from beat_cnt 0.
